// File: rtl/flash_read_responder.sv
// rtl/flash_read_responder.sv - single wait-stated parallel flash read per controller request
module flash_read_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_ready,
  input  logic [ADDR_W-1:0] flash_address,
  output logic [DATA_W-1:0] flashData_out,
  output logic              flash_valid,
  output logic              flash_busy,
  output logic [ADDR_W-1:0] fl_addr,
  output logic              fl_ce_n,
  output logic              fl_oe_n,
  input  logic [DATA_W-1:0] fl_dq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  state_t            state, state_d;
  logic [3:0]        wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0] fl_addr_d;
  logic [DATA_W-1:0] data_d;
  logic              ce_n_d, oe_n_d, valid_d;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      fl_addr       <= '0;
      fl_ce_n       <= 1'b1;
      fl_oe_n       <= 1'b1;
      flashData_out <= '0;
      flash_valid   <= 1'b0;
    end else begin
      state         <= state_d;
      wait_cnt      <= wait_cnt_d;
      fl_addr       <= fl_addr_d;
      fl_ce_n       <= ce_n_d;
      fl_oe_n       <= oe_n_d;
      flashData_out <= data_d;
      flash_valid   <= valid_d;
    end
  end

  // fl_addr always holds the most recently accepted address, so it also
  // serves as the "last address" reference for repeat-request filtering.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    fl_addr_d  = fl_addr;
    ce_n_d     = fl_ce_n;
    oe_n_d     = fl_oe_n;
    data_d     = flashData_out;
    valid_d    = 1'b0;
    accept     = 1'b0;

    case (state)
      S_IDLE: accept = flash_ready;
      S_SETUP: begin
        state_d    = S_WAIT;
        oe_n_d     = 1'b0;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt + 4'd1;
        if (wait_cnt == LAST_WAIT) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
        data_d  = fl_dq;
        valid_d = 1'b1;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
      end
      S_HOLD: begin
        if (!flash_ready) state_d = S_IDLE;
        else              accept  = (flash_address != fl_addr);
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d   = S_SETUP;
      fl_addr_d = flash_address;
      ce_n_d    = 1'b0;
    end
  end

  assign flash_busy = (state == S_SETUP) || (state == S_WAIT) || (state == S_CAPTURE);

endmodule
